// File: rtl/led_inout_sequencer_pkg.sv
// Shared types and constants for the LED inside-out / outside-in sequencer.
// FSM state encodings and the direction constants captured on start.
package led_inout_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic DIR_INOUT = 1'b0;
    localparam logic DIR_OUTIN = 1'b1;

endpackage

// File: rtl/led_inout_sequencer_tick_gen.sv
// Enable-gated frame tick divider: counts 0..CLK_DIV-1 while enabled.
// Emits a clock-enable tick on the last count; clr has priority over en.
module tick_gen #(
    parameter int CLK_DIV = 2500000,
    parameter int CNT_W   = 27
) (
    input  logic clki,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the async reset clears them immediately.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_inout_sequencer.sv
// LED bar sequencer: steps frames 0..N_LED/2 of an inside-out or outside-in fill,
// one frame per divider tick, with optional looping and a done pulse on completion.
module led_inout_sequencer
    import led_inout_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 2500000,
    parameter int N_LED   = 8,
    parameter int CNT_W   = 27
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             loop,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int H       = N_LED / 2;
    localparam int FRAME_W = $clog2(H + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(H);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               dir_q, dir_d;
    logic [N_LED-1:0]   led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick;
    logic               tick_clr;

    // Counter sits at zero in IDLE and restarts on the edge that accepts start.
    assign tick_clr = (state_q == ST_IDLE) || stop;

    tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .clki  (clki),
        .rst_n (rst_n),
        .en    (state_q == ST_RUN),
        .clr   (tick_clr),
        .tick  (tick)
    );

    function automatic logic [N_LED-1:0] frame_pattern(input logic [FRAME_W-1:0] k_in,
                                                       input logic d);
        logic [N_LED-1:0] pat;
        int k;
        k = int'(k_in);
        for (int i = 0; i < N_LED; i++) begin
            if (d == DIR_OUTIN) pat[i] = (i < k) || (i >= N_LED - k);
            else                pat[i] = (i >= H - k) && (i <= H + k - 1);
        end
        return pat;
    endfunction

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                led_d  = '0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    dir_d   = dir;
                    frame_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    frame_d = '0;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        led_d   = '0;
                        if (!loop) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        frame_d = frame_q + 1'b1;
                        led_d   = frame_pattern(frame_q + 1'b1, dir_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            dir_q   <= DIR_INOUT;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_inout_sequencer.sv
// Directed bench for led_inout_sequencer: an 8-LED instance with CLK_DIV=4
// and a 2-LED instance with CLK_DIV=1, expected patterns computed by hand.
module tb_led_inout_sequencer;

    logic       clki;
    logic       rst_n;
    logic       start, stop, dir, loop;
    logic [7:0] led;
    logic       busy, done;
    logic       start2, stop2, dir2, loop2;
    logic [1:0] led2;
    logic       busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    led_inout_sequencer #(.CLK_DIV(4), .N_LED(8), .CNT_W(3)) u_dut (
        .clki  (clki),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .loop  (loop),
        .led   (led),
        .busy  (busy),
        .done  (done)
    );

    led_inout_sequencer #(.CLK_DIV(1), .N_LED(2), .CNT_W(1)) u_dut_small (
        .clki  (clki),
        .rst_n (rst_n),
        .start (start2),
        .stop  (stop2),
        .dir   (dir2),
        .loop  (loop2),
        .led   (led2),
        .busy  (busy2),
        .done  (done2)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    task automatic expect_main(input string name, input logic [7:0] w_led,
                               input logic w_busy, input logic w_done);
        n_tests++;
        if ({led, busy, done} !== {w_led, w_busy, w_done}) begin
            n_fail++;
            $display("FAIL %s: got led=%h busy=%b done=%b, want led=%h busy=%b done=%b",
                     name, led, busy, done, w_led, w_busy, w_done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 0; stop = 0; dir = 0; loop = 0;
        start2 = 0; stop2 = 0; dir2 = 0; loop2 = 0;
        #12;
        expect_main("reset_state", 8'h00, 1'b0, 1'b0);
        n_tests++;
        if ({led2, busy2, done2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state_small: got %b want 0000", {led2, busy2, done2});
        end
        rst_n = 1'b1;
        step(2);
        expect_main("idle_after_reset", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        start = 1; dir = 0; loop = 0;
        step(1);
        start = 0;
        step(8);
        expect_main("rst_midrun_frame2", 8'h3C, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_main("rst_midrun_async", 8'h00, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step(6);
        expect_main("rst_midrun_stays_idle", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_inout;
        logic [7:0] want [5];
        want = '{8'h00, 8'h18, 8'h3C, 8'h7E, 8'hFF};
        dir = 0; loop = 0; start = 1;
        step(1);
        start = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step(4);
            expect_main($sformatf("inout_frame%0d", k), want[k], 1'b1, 1'b0);
        end
        step(4);
        expect_main("inout_done", 8'h00, 1'b0, 1'b1);
        step(1);
        expect_main("inout_done_one_cycle", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_outin;
        logic [7:0] want [5];
        want = '{8'h00, 8'h81, 8'hC3, 8'hE7, 8'hFF};
        dir = 1; loop = 0; start = 1;
        step(1);
        start = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step(4);
            if (k == 1) dir = 0;
            if (k == 3) dir = 1;
            if (k == 2) dir = 0;
            expect_main($sformatf("outin_frame%0d", k), want[k], 1'b1, 1'b0);
        end
        step(4);
        expect_main("outin_done", 8'h00, 1'b0, 1'b1);
        dir = 0;
        step(1);
    endtask

    task automatic test_loop;
        dir = 0; loop = 1; start = 1;
        step(1);
        start = 0;
        step(16);
        expect_main("loop_p1_ff", 8'hFF, 1'b1, 1'b0);
        step(4);
        expect_main("loop_p1_wrap", 8'h00, 1'b1, 1'b0);
        step(4);
        expect_main("loop_p2_frame1", 8'h18, 1'b1, 1'b0);
        step(16);
        expect_main("loop_p2_wrap", 8'h00, 1'b1, 1'b0);
        loop = 0;
        step(16);
        expect_main("loop_p3_ff", 8'hFF, 1'b1, 1'b0);
        step(4);
        expect_main("loop_final_done", 8'h00, 1'b0, 1'b1);
        step(1);
        expect_main("loop_done_one_cycle", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_stop;
        dir = 0; loop = 0; start = 1;
        step(1);
        start = 0;
        step(9);
        expect_main("stop_before", 8'h3C, 1'b1, 1'b0);
        stop = 1;
        step(1);
        expect_main("stop_after", 8'h00, 1'b0, 1'b0);
        stop = 0;
        step(5);
        expect_main("stop_no_done_later", 8'h00, 1'b0, 1'b0);
        start = 1; stop = 1;
        step(1);
        expect_main("start_stop_same_cycle", 8'h00, 1'b0, 1'b0);
        start = 0; stop = 0;
        step(1);
        expect_main("start_stop_stays_idle", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_small;
        logic [3:0] want [5];
        // {led2, busy2, done2} on E0..E0+4 with start held high
        want = '{4'b0010, 4'b1110, 4'b0001, 4'b0010, 4'b1110};
        start2 = 1;
        for (int e = 0; e < 5; e++) begin
            step(1);
            n_tests++;
            if ({led2, busy2, done2} !== want[e]) begin
                n_fail++;
                $display("FAIL small_edge%0d: got led=%b busy=%b done=%b, want %b",
                         e, led2, busy2, done2, want[e]);
            end
        end
        start2 = 0;
        step(3);
        n_tests++;
        if ({led2, busy2} !== 3'b000) begin
            n_fail++;
            $display("FAIL small_idle_end: got led=%b busy=%b, want 000", led2, busy2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_run();
        test_inout();
        test_outin();
        test_loop();
        test_stop();
        test_small();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
